// File: rtl/temporal_encoder_if.sv
// Load/start handshake and temporal event bus between the binary datapath
// and the race-logic encoder.
interface temporal_encoder_if #(
  parameter int NUM_CH = 2,
  parameter int W      = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [NUM_CH*W-1:0]   in_val;
  logic [1:0]            in_mode;
  logic                  start;
  logic [NUM_CH-1:0]     spk;
  logic                  busy;
  logic                  done;

  modport master (
    output in_valid, in_val, in_mode, start,
    input  in_ready, spk, busy, done
  );

  modport slave (
    input  in_valid, in_val, in_mode, start,
    output in_ready, spk, busy, done
  );
endinterface

// File: rtl/temporal_encoder.sv
// Binary-to-temporal encoder: each channel fires its edge or pulse a number
// of cycles after start equal to its loaded value; all-ones means never.
module temporal_encoder #(
  parameter int NUM_CH  = 2,
  parameter int W       = 3,
  parameter int PULSE_W = 2
) (
  input  logic                 aclk,
  input  logic                 grst,
  temporal_encoder_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [W-1:0] ZERO      = {W{1'b0}};
  localparam logic [W-1:0] ONE       = W'(1);
  localparam logic [W-1:0] NEVER     = {W{1'b1}};
  localparam logic [W-1:0] T_LAST    = W'((2 ** W) - 2);
  localparam logic [W-1:0] PULSE_CNT = W'(PULSE_W);

  state_t                state_r;
  state_t                state_nxt_s;
  logic [W-1:0]          t_r;
  logic [1:0]            mode_r;
  logic [NUM_CH*W-1:0]   val_r;
  logic [NUM_CH-1:0]     spk_r;
  logic [W-1:0]          pcnt_r [NUM_CH];
  logic                  idle_lvl_s;
  logic                  new_idle_lvl_s;

  assign idle_lvl_s     = (mode_r == 2'd1);
  assign new_idle_lvl_s = (bus.in_mode == 2'd1);

  // State register
  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) state_nxt_s = ARMED;
        else              state_nxt_s = IDLE;
      end
      ARMED: begin
        if (bus.start) state_nxt_s = RUN;
        else           state_nxt_s = ARMED;
      end
      RUN: begin
        if (t_r == T_LAST) state_nxt_s = DONE;
        else               state_nxt_s = RUN;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Window counter, captured operands and per-channel event generation
  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      t_r    <= ZERO;
      mode_r <= 2'd0;
      val_r  <= {(NUM_CH*W){1'b0}};
      spk_r  <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) pcnt_r[i] <= ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            val_r  <= bus.in_val;
            // Reserved mode 3 collapses to rising edge.
            mode_r <= (bus.in_mode == 2'd3) ? 2'd0 : bus.in_mode;
            spk_r  <= {NUM_CH{new_idle_lvl_s}};
            for (int i = 0; i < NUM_CH; i++) pcnt_r[i] <= ZERO;
          end
        end
        ARMED: begin
          t_r <= ZERO;
        end
        RUN: begin
          t_r <= t_r + ONE;
          for (int i = 0; i < NUM_CH; i++) begin
            if ((val_r[i*W +: W] == t_r) && (val_r[i*W +: W] != NEVER)) begin
              spk_r[i]  <= ~idle_lvl_s;
              pcnt_r[i] <= (mode_r == 2'd2) ? PULSE_CNT : ZERO;
            end else if (pcnt_r[i] != ZERO) begin
              // Pulse countdown; the last count restores the idle level.
              pcnt_r[i] <= pcnt_r[i] - ONE;
              if (pcnt_r[i] == ONE) spk_r[i] <= idle_lvl_s;
            end
          end
        end
        DONE: begin
          t_r   <= ZERO;
          spk_r <= {NUM_CH{idle_lvl_s}};
          for (int i = 0; i < NUM_CH; i++) pcnt_r[i] <= ZERO;
        end
        default: begin
          t_r <= ZERO;
        end
      endcase
    end
  end

  assign bus.spk      = spk_r;
  assign bus.in_ready = (state_r == IDLE);
  assign bus.busy     = (state_r != IDLE);
  assign bus.done     = (state_r == DONE);

endmodule

// File: doc/temporal_encoder.md
Name: temporal_encoder

Overview:
- Converts binary values into race-logic temporal events. It is the transmitter for the temporal comparators (equal, etc.) that consume edge- and pulse-coded signals.
- Per gamma window, channel i emits its event (rising edge, falling edge, or fixed-width pulse) a number of aclk cycles after start equal to its loaded value.
- The all-ones value encodes "never" (infinity).
- Sits between the binary datapath and the temporal primitive arrays.

Parameters:
- NUM_CH, 2, number of independent output channels
- W, 3, value width per channel; window length is 2^W-1 cycles
- PULSE_W, 2, high time in cycles of a pulse-mode event (1 .. 2^W-1)

Ports:
- aclk  input  1  clock
- grst  input  1  asynchronous active-low reset
- in_valid  input  1  load request for in_val/in_mode
- in_ready  output  1  high only in IDLE
- in_val  input  NUM_CH*W  channel i value at [i*W +: W]
- in_mode  input  2  0 = rising edge, 1 = falling edge, 2 = pulse, 3 = reserved (treated as 0)
- start  input  1  begins the window; sampled only in ARMED
- spk  output  NUM_CH  temporal event outputs, registered
- busy  output  1  high in ARMED, RUN and DONE
- done  output  1  one-cycle end-of-window strobe

Behaviour:
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- Reset (grst=0, asynchronous): state=IDLE, t=0, mode register=0, value registers=0, spk=0, done=0, busy=0, in_ready=1. Assertion in any state (including mid-RUN) aborts immediately; the partial window is lost. Deassertion is synchronised externally.
- Idle level: 0 in rising/pulse mode, 1 in falling mode. Event level is the opposite.
- IDLE:
  - in_ready=1; spk at idle level of the stored mode.
  - in_valid && in_ready on an edge: capture in_val and in_mode, go to ARMED.
  - spk is driven to the new mode's idle level at the same edge (falling mode -> all ones).
  - start is ignored in IDLE.
- ARMED:
  - in_ready=0; in_valid is ignored and values are held.
  - start=1 at edge k: go to RUN with t=0.
- RUN:
  - t counts 0 .. 2^W-2, one per cycle.
  - Channel i with value v != all-ones: at the edge ending the cycle where t==v (edge k+v+1), spk[i] goes to event level.
  - Rising/falling modes: spk[i] stays at event level until the DONE->IDLE edge.
  - Pulse mode: spk[i] returns to idle level after PULSE_W cycles, or is cut off at the DONE->IDLE edge if that comes first.
  - Value all-ones: spk[i] never leaves idle level.
  - Equal values on several channels: those channels transition on the same edge (this is the simultaneous-arrival case for downstream equal).
  - At the edge ending t==2^W-2 (edge k+2^W-1): go to DONE.
- DONE (exactly one cycle):
  - done=1; spk held, so the consumer samples the final pattern together with done.
  - Next edge: go to IDLE, done=0, all spk return to idle level.
- No back-to-back windows: a new load is only possible after returning to IDLE.
- Reserved mode 3: captured as 0.

Test Plan:
- (NUM_CH=2, W=3, PULSE_W=2; start sampled at edge k)
- Rising: load {2,5}, mode 0, start -> spk[0] 0->1 at k+3, spk[1] 0->1 at k+6; done high k+7..k+8; both spk=0 and in_ready=1 after k+8.
- Falling: load {5,2}, mode 1 -> spk=2'b11 one edge after load; spk[1] 1->0 at k+3, spk[0] 1->0 at k+6; both return to 1 at k+8.
- Simultaneous and never: load {3,3} mode 0 -> both rise at k+4. Load {7,0} mode 0 -> spk[1] rises at k+1, spk[0] stays 0 for the whole window; done at k+7.
- Pulse and truncation: load {1,6} mode 2 -> spk[0] high k+2..k+4 (2 cycles); spk[1] high k+7..k+8 only (truncated to 1 cycle); done at k+7.
- Handshake: in_valid held high through ARMED/RUN with changing in_val -> in_ready=0, events follow the first load only. start pulsed in IDLE -> no state change, busy stays 0.
- Reset mid-run: grst low at k+4 of a rising {2,5} window -> spk=0, busy=0, done=0, in_ready=1 immediately. After release, a new {1,1} load and start -> both rise at k'+2.
